// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle RV32I core
// Decodes the opcode into a state sequence and drives every datapath select and strobe.
module multicycle_control #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int STATE_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] current_state,
  output logic               pc_update,
  output logic               branch,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic               adr_src,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               illegal
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JALR     = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JALRWB   = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_LUI      = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_AUIPC    = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(15);

  logic [STATE_W-1:0] state_q, state_d;
  logic mem_ok;
  logic pc_update_c, branch_c, ir_write_c, reg_write_c, mem_write_c;

  // Without the handshake every memory state completes in a single cycle.
  assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_TRAP;
    case (state_q)
      S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ok ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRWB;
      S_JALRWB:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
      default:    state_d = S_TRAP;
    endcase
  end

  always_comb begin
    pc_update_c = 1'b0;
    branch_c    = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write_c  = mem_ok;
        pc_update_c = mem_ok;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; reg_write_c = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_write_c = 1'b1; end
      S_EXECUTER: begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXECUTEI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB:    reg_write_c = 1'b1;
      S_BRANCH:   begin alu_src_a = 2'b10; alu_op = 2'b01; branch_c = 1'b1; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update_c = 1'b1; end
      S_JALR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        result_src  = 2'b10;
        pc_update_c = 1'b1;
      end
      S_JALRWB: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        reg_write_c = 1'b1;
      end
      S_LUI:      begin alu_src_a = 2'b11; alu_src_b = 2'b01; end
      S_AUIPC:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_TRAP:     illegal = 1'b1;
      default:    illegal = 1'b0;
    endcase
  end

  // Reset kills every write strobe at once so an aborted instruction leaves no partial write.
  assign pc_update     = pc_update_c & ~reset;
  assign branch        = branch_c    & ~reset;
  assign ir_write      = ir_write_c  & ~reset;
  assign reg_write     = reg_write_c & ~reset;
  assign mem_write     = mem_write_c & ~reset;
  assign current_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Two instances: handshake/halting defaults, and no-handshake/returning-trap variant.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_m, reset_a, mr_m, mr_a;
  logic [6:0] op_m, op_a;
  logic [3:0] st_m, st_a;
  logic       pc_update_m, branch_m, ir_write_m, reg_write_m, mem_write_m, adr_src_m, illegal_m;
  logic       pc_update_a, branch_a, ir_write_a, reg_write_a, mem_write_a, adr_src_a, illegal_a;
  logic [1:0] result_src_m, alu_src_a_m, alu_src_b_m, alu_op_m;
  logic [1:0] result_src_a, alu_src_a_a, alu_src_b_a, alu_op_a;
  logic [14:0] out_m, out_a;

  multicycle_control dut_m (
    .clk(clk), .reset(reset_m), .op(op_m), .mem_ready(mr_m), .current_state(st_m),
    .pc_update(pc_update_m), .branch(branch_m), .ir_write(ir_write_m), .reg_write(reg_write_m),
    .mem_write(mem_write_m), .adr_src(adr_src_m), .result_src(result_src_m),
    .alu_src_a(alu_src_a_m), .alu_src_b(alu_src_b_m), .alu_op(alu_op_m), .illegal(illegal_m)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0), .HALT_ON_ILLEGAL(1'b0), .STATE_W(4)) dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .mem_ready(mr_a), .current_state(st_a),
    .pc_update(pc_update_a), .branch(branch_a), .ir_write(ir_write_a), .reg_write(reg_write_a),
    .mem_write(mem_write_a), .adr_src(adr_src_a), .result_src(result_src_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a), .illegal(illegal_a)
  );

  assign out_m = {pc_update_m, branch_m, ir_write_m, reg_write_m, mem_write_m, adr_src_m,
                  result_src_m, alu_src_a_m, alu_src_b_m, alu_op_m, illegal_m};
  assign out_a = {pc_update_a, branch_a, ir_write_a, reg_write_a, mem_write_a, adr_src_a,
                  result_src_a, alu_src_a_a, alu_src_b_a, alu_op_a, illegal_a};

  int checks = 0;
  int passed = 0;
  int exp_s[$];
  bit exp_r[$];
  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  int legal_cycles [9] = '{5, 4, 4, 4, 3, 4, 4, 4, 4};

  // Expected control word per state: {pc,br,ir,rw,mw,adr,res,a,b,aluop,illegal}
  function automatic logic [14:0] exp_out(int s, bit mr, bit hs);
    logic pc = 0, br = 0, ir = 0, rw = 0, mw = 0, adr = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0, alu = 0;
    case (s)
      0:  begin b = 2; res = 2; pc = hs ? mr : 1'b1; ir = hs ? mr : 1'b1; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; alu = 2; end
      7:  begin a = 2; b = 1; alu = 2; end
      8:  rw = 1;
      9:  begin a = 2; alu = 1; br = 1; end
      10: begin a = 1; b = 2; pc = 1; end
      11: begin a = 2; b = 1; res = 2; pc = 1; end
      12: begin a = 1; b = 2; res = 2; rw = 1; end
      13: begin a = 3; b = 1; end
      14: begin a = 1; b = 1; end
      default: ill = 1;
    endcase
    return {pc, br, ir, rw, mw, adr, res, a, b, alu, ill};
  endfunction

  function automatic bit is_legal(logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(int s, bit r);
    exp_s.push_back(s);
    exp_r.push_back(r);
  endtask

  // Instruction-level model: the state path an opcode takes, with memory wait cycles.
  task automatic build(logic [6:0] o, int wf, int wm, bit hs);
    if (hs) begin repeat (wf) push(0, 0); push(0, 1); end
    else push(0, 1'($urandom));
    push(1, 1'($urandom));
    case (o)
      7'b0000011, 7'b0100011: begin
        push(2, 1'($urandom));
        if (hs) begin repeat (wm) push(o[5] ? 5 : 3, 0); push(o[5] ? 5 : 3, 1); end
        else push(o[5] ? 5 : 3, 1'($urandom));
        if (!o[5]) push(4, 1'($urandom));
      end
      7'b0110011: begin push(6, 1'($urandom)); push(8, 1'($urandom)); end
      7'b0010011: begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
      7'b1100011: push(9, 1'($urandom));
      7'b1101111: begin push(10, 1'($urandom)); push(8, 1'($urandom)); end
      7'b1100111: begin push(11, 1'($urandom)); push(12, 1'($urandom)); end
      7'b0110111: begin push(13, 1'($urandom)); push(8, 1'($urandom)); end
      7'b0010111: begin push(14, 1'($urandom)); push(8, 1'($urandom)); end
      default:    push(15, 1'($urandom));
    endcase
  endtask

  task automatic reset_both();
    reset_m = 1; reset_a = 1;
    repeat (2) @(negedge clk);
    reset_m = 0; reset_a = 0;
  endtask

  task automatic test_reset();
    reset_m = 1; reset_a = 1; mr_m = 1; op_m = 7'b0110011;
    @(posedge clk); #1;
    checks++; if (st_m !== 4'd0) $display("FAIL reset_state got=%0d exp=0", st_m); else passed++;
    checks++; if (out_m[14:10] !== 5'b0) $display("FAIL reset_strobes got=%b exp=00000", out_m[14:10]); else passed++;
    @(negedge clk);
    reset_m = 0;
  endtask

  task automatic test_reset_mid_store();
    reset_both();
    op_m = 7'b0100011; mr_m = 1;
    @(negedge clk); mr_m = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (st_m !== 4'd5 || mem_write_m !== 1'b1)
      $display("FAIL store_before_reset state=%0d mw=%b exp state=5 mw=1", st_m, mem_write_m); else passed++;
    reset_m = 1; mr_m = 1; #1;
    checks++; if (out_m[14:10] !== 5'b0) $display("FAIL reset_drop_mw strobes=%b exp=00000", out_m[14:10]); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (st_m !== 4'd0 || out_m[14:10] !== 5'b0)
        $display("FAIL reset_hold cyc=%0d state=%0d strobes=%b exp state=0 strobes=00000", i, st_m, out_m[14:10]);
      else passed++;
    end
    @(negedge clk);
    reset_m = 0;
  endtask

  // Replays the model's expected path against the main instance.
  task automatic test_seq_main(string name, logic [6:0] o, int wf, int wm);
    exp_s.delete(); exp_r.delete();
    build(o, wf, wm, 1'b1);
    push(0, 1'b0);
    for (int i = 0; i < exp_s.size(); i++) begin
      op_m = o; mr_m = exp_r[i]; #1;
      checks++; if (st_m !== 4'(exp_s[i]))
        $display("FAIL %s state cyc=%0d got=%0d exp=%0d", name, i, st_m, exp_s[i]); else passed++;
      checks++; if (out_m !== exp_out(exp_s[i], exp_r[i], 1'b1))
        $display("FAIL %s outputs cyc=%0d got=%h exp=%h", name, i, out_m, exp_out(exp_s[i], exp_r[i], 1'b1));
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_store_nohs();
    int seq [5] = '{0, 1, 2, 5, 0};
    int mw_cnt = 0;
    reset_both();
    op_a = 7'b0100011; mr_a = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (st_a !== 4'(seq[i])) $display("FAIL sw_nohs state cyc=%0d got=%0d exp=%0d", i, st_a, seq[i]); else passed++;
      if (mem_write_a) mw_cnt++;
      @(negedge clk);
    end
    checks++; if (mw_cnt !== 1) $display("FAIL sw_nohs mem_write_cycles got=%0d exp=1", mw_cnt); else passed++;
  endtask

  task automatic test_trap_halt();
    reset_both();
    exp_s.delete(); exp_r.delete();
    build(7'b1111111, 0, 0, 1'b1);
    repeat (9) push(15, 1'($urandom));
    for (int i = 0; i < exp_s.size(); i++) begin
      op_m = 7'b1111111; mr_m = exp_r[i]; #1;
      checks++; if (st_m !== 4'(exp_s[i]) || illegal_m !== (exp_s[i] == 15))
        $display("FAIL trap_halt cyc=%0d state=%0d ill=%b exp=%0d", i, st_m, illegal_m, exp_s[i]); else passed++;
      @(negedge clk);
    end
    reset_m = 1; @(posedge clk); #1;
    checks++; if (st_m !== 4'd0 || illegal_m !== 1'b0)
      $display("FAIL trap_reset state=%0d ill=%b exp state=0 ill=0", st_m, illegal_m); else passed++;
    @(negedge clk); reset_m = 0;
  endtask

  task automatic test_cycle_counts();
    reset_both();
    mr_m = 1;
    foreach (legal_ops[k]) begin
      int cnt = 1;
      op_m = legal_ops[k];
      @(negedge clk);
      while (st_m !== 4'd0 && cnt < 20) begin cnt++; @(negedge clk); end
      checks++; if (cnt !== legal_cycles[k])
        $display("FAIL cycles op=%b got=%0d exp=%0d", legal_ops[k], cnt, legal_cycles[k]); else passed++;
    end
  endtask

  task automatic test_random_main();
    reset_both();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o = legal_ops[$urandom_range(0, 8)];
      exp_s.delete(); exp_r.delete();
      build(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      for (int i = 0; i < exp_s.size(); i++) begin
        op_m = o; mr_m = exp_r[i]; #1;
        checks++; if (st_m !== 4'(exp_s[i]) || out_m !== exp_out(exp_s[i], exp_r[i], 1'b1))
          $display("FAIL rand_main n=%0d cyc=%0d state=%0d out=%h exp state=%0d out=%h", n, i, st_m, out_m,
                   exp_s[i], exp_out(exp_s[i], exp_r[i], 1'b1));
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random_alt();
    reset_both();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o = legal_ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) begin
        do o = 7'($urandom); while (is_legal(o));
      end
      exp_s.delete(); exp_r.delete();
      build(o, 0, 0, 1'b0);
      for (int i = 0; i < exp_s.size(); i++) begin
        op_a = o; mr_a = exp_r[i]; #1;
        checks++; if (st_a !== 4'(exp_s[i]) || out_a !== exp_out(exp_s[i], exp_r[i], 1'b0))
          $display("FAIL rand_alt n=%0d op=%b cyc=%0d state=%0d out=%h exp state=%0d out=%h", n, o, i, st_a, out_a,
                   exp_s[i], exp_out(exp_s[i], exp_r[i], 1'b0));
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset_m = 1; reset_a = 1; mr_m = 0; mr_a = 0; op_m = 0; op_a = 0;
    @(negedge clk);
    test_reset();
    test_reset_mid_store();
    reset_both();
    test_seq_main("rtype", 7'b0110011, 0, 0);
    test_seq_main("lw_waits", 7'b0000011, 2, 3);
    test_seq_main("jalr", 7'b1100111, 0, 0);
    test_seq_main("sw_waits", 7'b0100011, 1, 2);
    test_store_nohs();
    test_trap_halt();
    test_cycle_counts();
    test_random_main();
    test_random_alt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Full main-control FSM for the multicycle RV32I core. Next generation of the state-sequencing-only controller.
- Decodes opcode/funct bits from the instruction register and drives every datapath select and strobe.
- Adds synchronous reset, a parametrised memory wait-state handshake, JALR/LUI/AUIPC paths, and an illegal-opcode trap.
- Sits between the instruction register and the datapath muxes/ALU decoder.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1. 0: mem_ready ignored, each memory state takes 1 cycle.
- HALT_ON_ILLEGAL, 1, 1: TRAP is absorbing (only reset exits). 0: TRAP returns to FETCH after 1 cycle.
- STATE_W, 4, width of current_state output. Must be >=4.

Ports:
- clk  in  1  core clock, all state changes on posedge.
- reset  in  1  synchronous, active-high.
- op  in  7  instr[6:0].
- mem_ready  in  1  memory access completes this cycle.
- current_state  out  STATE_W  encoded state, for debug/trace.
- pc_update  out  1  PC write strobe (unconditional).
- branch  out  1  conditional PC write; the datapath ANDs it with zero/compare.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- mem_write  out  1  data memory write.
- adr_src  out  1  0=PC, 1=ALUOut.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=const 4.
- alu_op  out  2  00=add, 01=branch compare, 10=funct-decoded.
- illegal  out  1  high while in TRAP.

Behaviour:
- Moore outputs, combinational from current_state, except that ir_write/pc_update in FETCH are gated by mem_ready when MEM_HANDSHAKE=1.
- Unlisted outputs are 0 in every state.
- Reset: on a clk edge with reset=1, state goes to FETCH. While reset=1, all strobes (pc_update, branch, ir_write, reg_write, mem_write) are forced to 0. Reset mid-instruction aborts it with no partial write.
- Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, JALRWB=12, LUI=13, AUIPC=14, TRAP=15.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_update=mem_ready. Goes to DECODE when mem_ready=1, else holds.
- DECODE: a=01, b=01, alu_op=00 (precomputes the branch/JAL target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other -> TRAP
- MEMADR: a=10, b=01, alu_op=00. Next is MEMWRITE if op[5]=1, else MEMREAD.
- MEMREAD: adr_src=1, result_src=00. Goes to MEMWB on mem_ready, else holds.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held every cycle until mem_ready. Then FETCH.
- EXECUTER: a=10, b=00, alu_op=10. Next ALUWB.
- EXECUTEI: a=10, b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1. Next FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB.
- JALR: a=10, b=01, alu_op=00, result_src=10, pc_update=1. Next JALRWB.
- JALRWB: a=01, b=10, alu_op=00, result_src=10, reg_write=1. Next FETCH.
- LUI: a=11, b=01, alu_op=00. Next ALUWB.
- AUIPC: a=01, b=01, alu_op=00. Next ALUWB.
- TRAP: illegal=1, no strobes. Next is TRAP if HALT_ON_ILLEGAL, else FETCH.
- Unused encodings (only reachable if STATE_W>4) go to TRAP.
- Cycle counts with zero memory wait:
  - R/I-ALU, LUI, AUIPC, JAL: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jalr: 4
- Each cycle with mem_ready=0 in a memory state adds 1 cycle.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.

Test Plan:
- Reset held 3 cycles mid-MEMWRITE (mem_ready=0) -> mem_write drops to 0 in the first reset cycle; current_state=0 after the first edge; no strobes while reset=1.
- op=0110011, mem_ready=1 -> states 0,1,6,8,0. reg_write=1 only in state 8; ir_write=1 only in cycle 0.
- op=0000011, MEM_HANDSHAKE=1, mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> states 0,0,0,1,2,3,3,3,3,4,0. ir_write=1 only on the third FETCH cycle.
- op=0100011, MEM_HANDSHAKE=0, mem_ready=0 constant -> states 0,1,2,5,0. mem_write=1 for exactly one cycle.
- op=1100111 -> states 0,1,11,12,0. pc_update=1 in state 11, reg_write=1 in state 12, b=10 in state 12.
- op=1111111 -> TRAP (15), illegal=1. HALT_ON_ILLEGAL=1: stays 15 for 10 cycles until reset. HALT_ON_ILLEGAL=0: FETCH on the next cycle.
